// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// FSM states, ALU operation classes and datapath mux selects.
package mips_ctrl_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Controller states, 4-bit encoding
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // ALU operation class handed from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // alucontrol encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the FSM's operation class plus the
// R-type funct field onto the 3-bit alucontrol of the datapath ALU.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Fixed add/sub for address and branch work, funct lookup for R-type;
  // unknown functs fall back to add so the writeback still happens.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM. Drives every datapath enable and mux select
// from the current state, and counts instructions that pass through FETCH.
module mips_multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pcen,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_instrCount;

  logic   w_pcwrite;
  logic   w_branch;
  logic   w_irwrite;
  logic   w_regwrite;
  logic   w_memwrite;
  aluop_t w_aluop;

  // State register; reset drops straight back to FETCH without waiting for clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_nextState;
  end

  // Retired-instruction counter: one tick per edge spent in FETCH, wraps freely
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_instrCount <= '0;
    else if (r_state == S_FETCH) r_instrCount <= r_instrCount + CNT_ONE;
  end

  // Per-state control decode and next-state selection; everything defaults to 0/add
  always_comb begin
    w_nextState = S_FETCH;
    w_pcwrite   = 1'b0;
    w_branch    = 1'b0;
    w_irwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_memwrite  = 1'b0;
    alusrca     = 1'b0;
    iord        = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    alusrcb     = SRCB_REG;
    pcsrc       = PC_ALU;
    w_aluop     = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_irwrite   = 1'b1;
        alusrcb     = SRCB_FOUR;
        w_pcwrite   = 1'b1;
        w_nextState = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: w_nextState = S_MEMADR;
          OP_RTYPE:     w_nextState = S_EXECUTE;
          OP_BEQ:       w_nextState = S_BRANCH;
          OP_ADDI:      w_nextState = S_ADDIEXEC;
          OP_J:         w_nextState = S_JUMP;
          default:      w_nextState = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca     = 1'b1;
        alusrcb     = SRCB_IMM;
        w_nextState = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord        = 1'b1;
        w_nextState = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca     = 1'b1;
        w_aluop     = ALUOP_FUNCT;
        w_nextState = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        pcsrc    = PC_ALUOUT;
        w_branch = 1'b1;
      end
      S_ADDIEXEC: begin
        alusrca     = 1'b1;
        alusrcb     = SRCB_IMM;
        w_nextState = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
      end
      S_JUMP: begin
        pcsrc     = PC_JUMP;
        w_pcwrite = 1'b1;
      end
      default: w_nextState = S_FETCH;
    endcase
  end

  // Architectural write strobes are gated by reset so nothing commits while it is held
  assign pcen        = ~reset & (w_pcwrite | (w_branch & zero));
  assign irwrite     = ~reset & w_irwrite;
  assign regwrite    = ~reset & w_regwrite;
  assign memwrite    = ~reset & w_memwrite;
  assign instr_count = r_instrCount;

  alu_decoder u_aluDecoder (
    .aluop      (w_aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Self-checking bench for the multicycle MIPS controller: a per-cycle
// vector table walks every instruction class, followed by hand-written
// sequences for mid-instruction reset and counter wrap.
module tb_mips_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;

  logic        pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [31:0] instrCount;

  logic        pcenW, memwriteW, irwriteW, regwriteW, alusrcaW, iordW, memtoregW, regdstW;
  logic [1:0]  alusrcbW, pcsrcW;
  logic [2:0]  alucontrolW;
  logic [3:0]  instrCountW;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [14:0] expWord;
  } vec_t;

  vec_t vecs[$];

  logic [14:0] eF, eD, eMA, eMR, eMWB, eMWR, eAWB, eAE, eAWBI, eJ;
  logic [14:0] actWord, actWordW;

  assign actWord  = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                     alusrcb, pcsrc, alucontrol};
  assign actWordW = {pcenW, memwriteW, irwriteW, regwriteW, alusrcaW, iordW, memtoregW, regdstW,
                     alusrcbW, pcsrcW, alucontrolW};

  mips_multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .instr_count(instrCount)
  );

  mips_multicycle_controller #(.CNT_W(4)) dutW (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcenW), .memwrite(memwriteW), .irwrite(irwriteW), .regwrite(regwriteW),
    .alusrca(alusrcaW), .iord(iordW), .memtoreg(memtoregW), .regdst(regdstW),
    .alusrcb(alusrcbW), .pcsrc(pcsrcW), .alucontrol(alucontrolW), .instr_count(instrCountW)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [14:0] ex(input logic pc, mw, ir, rw, asa, ior, m2r, rd,
                                     input logic [1:0] asb, pcs, input logic [2:0] alu);
    return {pc, mw, ir, rw, asa, ior, m2r, rd, asb, pcs, alu};
  endfunction

  function automatic logic [14:0] eEx(input logic [2:0] alu);
    return ex(0,0,0,0,1,0,0,0,2'b00,2'b00,alu);
  endfunction

  function automatic logic [14:0] eBr(input logic z);
    return ex(z,0,0,0,1,0,0,0,2'b00,2'b01,3'b110);
  endfunction

  task automatic addRow(input logic [5:0] o, input logic [5:0] f, input logic z,
                        input logic [14:0] e);
    vec_t v;
    v.op = o; v.funct = f; v.zero = z; v.expWord = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z);
    op = o; funct = f; zero = z;
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  initial begin
    eF    = ex(1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010);
    eD    = ex(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010);
    eMA   = ex(0,0,0,0,1,0,0,0,2'b10,2'b00,3'b010);
    eMR   = ex(0,0,0,0,0,1,0,0,2'b00,2'b00,3'b010);
    eMWB  = ex(0,0,0,1,0,0,1,0,2'b00,2'b00,3'b010);
    eMWR  = ex(0,1,0,0,0,1,0,0,2'b00,2'b00,3'b010);
    eAWB  = ex(0,0,0,1,0,0,0,1,2'b00,2'b00,3'b010);
    eAE   = ex(0,0,0,0,1,0,0,0,2'b10,2'b00,3'b010);
    eAWBI = ex(0,0,0,1,0,0,0,0,2'b00,2'b00,3'b010);
    eJ    = ex(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010);

    // LW: 5 cycles
    addRow(6'b100011, 6'h00, 0, eF);  addRow(6'b100011, 6'h00, 0, eD);
    addRow(6'b100011, 6'h00, 0, eMA); addRow(6'b100011, 6'h00, 0, eMR);
    addRow(6'b100011, 6'h00, 0, eMWB);
    // SW: 4 cycles, zero held high to show it is ignored outside BRANCH
    addRow(6'b101011, 6'h00, 1, eF);  addRow(6'b101011, 6'h00, 1, eD);
    addRow(6'b101011, 6'h00, 1, eMA); addRow(6'b101011, 6'h00, 1, eMWR);
    // R-type SUB
    addRow(6'b000000, 6'b100010, 0, eF); addRow(6'b000000, 6'b100010, 0, eD);
    addRow(6'b000000, 6'b100010, 0, eEx(3'b110)); addRow(6'b000000, 6'b100010, 0, eAWB);
    // R-type SLT
    addRow(6'b000000, 6'b101010, 0, eF); addRow(6'b000000, 6'b101010, 0, eD);
    addRow(6'b000000, 6'b101010, 0, eEx(3'b111)); addRow(6'b000000, 6'b101010, 0, eAWB);
    // R-type OR then unknown funct (falls back to add, still writes back)
    addRow(6'b000000, 6'b100101, 0, eF); addRow(6'b000000, 6'b100101, 0, eD);
    addRow(6'b000000, 6'b100101, 0, eEx(3'b001)); addRow(6'b000000, 6'b100101, 0, eAWB);
    addRow(6'b000000, 6'b111100, 0, eF); addRow(6'b000000, 6'b111100, 0, eD);
    addRow(6'b000000, 6'b111100, 0, eEx(3'b010)); addRow(6'b000000, 6'b111100, 0, eAWB);
    // ADDI
    addRow(6'b001000, 6'h00, 0, eF);  addRow(6'b001000, 6'h00, 0, eD);
    addRow(6'b001000, 6'h00, 0, eAE); addRow(6'b001000, 6'h00, 0, eAWBI);
    // BEQ taken, then not taken
    addRow(6'b000100, 6'h00, 1, eF); addRow(6'b000100, 6'h00, 1, eD);
    addRow(6'b000100, 6'h00, 1, eBr(1'b1));
    addRow(6'b000100, 6'h00, 0, eF); addRow(6'b000100, 6'h00, 0, eD);
    addRow(6'b000100, 6'h00, 0, eBr(1'b0));
    // J
    addRow(6'b000010, 6'h00, 0, eF); addRow(6'b000010, 6'h00, 0, eD);
    addRow(6'b000010, 6'h00, 0, eJ);
    // Illegal op: DECODE then straight back to FETCH
    addRow(6'b111111, 6'h00, 0, eF); addRow(6'b111111, 6'h00, 0, eD);

    // Power-on reset: strobes forced low, selects at FETCH values, counter cleared
    applyStimulus(6'b000000, 6'h00, 1'b0);
    reset = 1'b1;
    #12;
    checkOutput("reset_word", {17'd0, actWord},
                {17'd0, ex(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010)});
    checkOutput("reset_count", instrCount, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table walk: one row per clock, compared half a cycle after the edge
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].funct, vecs[i].zero);
      #1;
      checkOutput($sformatf("vec%0d", i), {17'd0, actWord}, {17'd0, vecs[i].expWord});
      checkOutput($sformatf("vec%0d_w4", i), {17'd0, actWordW}, {17'd0, vecs[i].expWord});
      @(negedge clk);
    end
    // 11 instructions have each passed FETCH once
    checkOutput("count_after_table", instrCount, 32'd11);

    // SW interrupted by reset while in MEMWR
    applyStimulus(6'b101011, 6'h00, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("memwr_before_reset", {31'd0, memwrite}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("memwr_reset_memwrite", {31'd0, memwrite}, 32'd0);
    checkOutput("memwr_reset_word", {17'd0, actWord},
                {17'd0, ex(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010)});
    checkOutput("memwr_reset_count", instrCount, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("post_reset_fetch", {17'd0, actWord}, {17'd0, eF});

    // Back-to-back jumps: 16 of them wrap the 4-bit counter to zero
    applyStimulus(6'b000010, 6'h00, 1'b0);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      @(negedge clk);
      #1;
      if (j == 7) checkOutput("jump_word", {17'd0, actWord}, {17'd0, eJ});
      @(negedge clk);
      #1;
      if (j == 14) checkOutput("wrap_count15", {28'd0, instrCountW}, 32'd15);
    end
    checkOutput("wrap_count0", {28'd0, instrCountW}, 32'd0);
    checkOutput("count32_after_jumps", instrCount, 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
- Control FSM for the multicycle MIPS core; sits directly upstream of the datapath.
- Consumes op, funct and zero from the datapath.
- Produces every per-cycle enable and mux select the datapath needs: pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst, alusrcb, pcsrc and alucontrol.
- Also produces memwrite for data memory and a retired-instruction counter for debug and verification.

Parameters:
CNT_W, 32, width of retired-instruction counter instr_count

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
op  input  6  instr[31:26] from datapath
funct  input  6  instr[5:0] from datapath
zero  input  1  ALU zero flag from datapath
pcen  output  1  PC register enable
memwrite  output  1  data memory write strobe
irwrite  output  1  instruction register enable
regwrite  output  1  register file write enable
alusrca  output  1  0 = PC, 1 = register A
iord  output  1  0 = PC address, 1 = ALUOut address
memtoreg  output  1  0 = ALUOut, 1 = memory data register
regdst  output  1  0 = rt, 1 = rd
alusrcb  output  2  00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2
pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
instr_count  output  CNT_W  count of instructions that completed FETCH

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset entry: state is forced to FETCH and instr_count to 0 immediately, independent of clk.
- Outputs during reset: while reset is high, pcen, irwrite, regwrite and memwrite are forced 0. All other outputs take their FETCH values.
- Output timing: all outputs are combinational from state. alucontrol additionally depends on funct. No registered outputs except instr_count.
- pcen = pcwrite | (branch & zero). pcwrite and branch are internal, per state.
- Unlisted signals in any state are 0. alucontrol defaults to add (aluop 00).
- Supported opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
- States (default values apply unless listed):
  - FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, pcwrite=1. Next state is DECODE.
  - DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op: LW/SW to MEMADR, RTYPE to EXECUTE, BEQ to BRANCH, ADDI to ADDIEXEC, J to JUMP. Any other op returns to FETCH with no architectural write.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. Next state is MEMRD for LW, MEMWR for SW.
  - MEMRD: iord=1. Next state is MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. Next state is FETCH.
  - MEMWR: iord=1, memwrite=1. Next state is FETCH.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10. Next state is ALUWB.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1. Next state is FETCH.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Next state is FETCH.
  - ADDIEXEC: alusrca=1, alusrcb=10, aluop=00. Next state is ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next state is FETCH.
  - JUMP: pcsrc=10, pcwrite=1. Next state is FETCH.
- ALU decode:
  - aluop 00 gives 010; aluop 01 gives 110.
  - aluop 10 decodes funct: 100000 to 010, 100010 to 110, 100100 to 000, 100101 to 001, 101010 to 111.
  - Unknown funct gives 010. The writeback still occurs.
- Cycle counts per instruction type: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal op 2.
- instr_count increments by 1 on every clk edge where state==FETCH and reset is low. It wraps modulo 2^CNT_W.
- BEQ with zero=0: pcen stays 0 in BRANCH and the PC keeps the FETCH-incremented value.
- zero is sampled only in BRANCH; it is ignored in all other states.
- Reset mid-instruction (e.g., in MEMWR): memwrite drops the moment reset rises. The FSM restarts at FETCH on the first edge after reset falls.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode and funct constants
  - the state enum (4-bit encoding)
  - aluop encodings
  - alucontrol encodings
  - alusrcb and pcsrc select encodings
- Natural sub-module: alu_decoder (aluop, funct to alucontrol), purely combinational.
- The FSM and instr_count live in the top module.

Test Plan:
- Reset asserted mid-cycle while in MEMWR: memwrite goes 0 asynchronously; state reads FETCH; instr_count is 0. After release, the first cycle shows irwrite=1, pcen=1, alusrcb=01.
- LW (op=100011): states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. regwrite=1, memtoreg=1, regdst=0 only in cycle 5; instr_count increases by 1.
- R-type SUB (funct=100010): EXECUTE shows alucontrol=110, alusrca=1, alusrcb=00. ALUWB shows regdst=1, regwrite=1. SLT (101010) gives 111.
- BEQ with zero=1 gives pcen=1 and pcsrc=01 in BRANCH. Repeat with zero=0: pcen=0. Both take 3 cycles.
- J (000010): JUMP has pcsrc=10, pcen=1. Illegal op 111111: DECODE then FETCH, with no regwrite or memwrite asserted at any point.
- Counter wrap with CNT_W=4: 16 back-to-back J instructions return instr_count to 0.
